// File: rtl/cordic_pkg.sv
// Shared constants for the float32 sin/cos CORDIC unit: rotation-angle table,
// gain constant, state encoding and mode codes.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    PACK = 2'd2
  } state_t;

  localparam logic        MODE_COS = 1'b0;
  localparam logic        MODE_SIN = 1'b1;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] K_FIX    = 32'h26DD_3B6A;

  // atan(2^-i) in Q2.30, truncated
  function automatic logic [31:0] atan_fix(input logic [4:0] i);
    logic [31:0] v;
    v = '0;
    case (i)
      5'd0:  v = 32'h3243_F6A8;
      5'd1:  v = 32'h1DAC_6705;
      5'd2:  v = 32'h0FAD_BAFC;
      5'd3:  v = 32'h07F5_6EA6;
      5'd4:  v = 32'h03FE_AB76;
      5'd5:  v = 32'h01FF_D55B;
      5'd6:  v = 32'h00FF_FAAA;
      5'd7:  v = 32'h007F_FF55;
      5'd8:  v = 32'h003F_FFEA;
      5'd9:  v = 32'h001F_FFFD;
      5'd10: v = 32'h000F_FFFF;
      5'd11: v = 32'h0007_FFFF;
      5'd12: v = 32'h0003_FFFF;
      5'd13: v = 32'h0001_FFFF;
      5'd14: v = 32'h0000_FFFF;
      5'd15: v = 32'h0000_7FFF;
      5'd16: v = 32'h0000_3FFF;
      5'd17: v = 32'h0000_1FFF;
      5'd18: v = 32'h0000_0FFF;
      5'd19: v = 32'h0000_07FF;
      5'd20: v = 32'h0000_03FF;
      5'd21: v = 32'h0000_01FF;
      5'd22: v = 32'h0000_00FF;
      5'd23: v = 32'h0000_007F;
      5'd24: v = 32'h0000_003F;
      5'd25: v = 32'h0000_001F;
      5'd26: v = 32'h0000_000F;
      5'd27: v = 32'h0000_0007;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/cordic_fix2float.sv
// Combinational signed Q2.FRAC_BITS to float32 converter; magnitudes below
// 2^-FTZ_EXP flush to +0.0, mantissa is truncated.
module cordic_fix2float #(
  parameter int unsigned FRAC_BITS = 30,
  parameter int unsigned FTZ_EXP   = 15
) (
  input  logic [31:0] fix,
  output logic [31:0] flt
);

  localparam logic [31:0] FTZ_LIMIT = 32'(1) << (FRAC_BITS - FTZ_EXP);
  localparam logic [7:0]  EXP_BIAS  = 8'(127 - FRAC_BITS);

  logic        sign;
  logic [31:0] mag;
  logic [4:0]  msb;
  logic [22:0] mant;
  logic [7:0]  expo;

  always_comb begin
    sign = fix[31];
    mag  = sign ? 32'(-fix) : fix;
    msb  = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (mag[b]) msb = 5'(b);
    end
    // normalise so the leading one sits at bit 31, then drop it
    mant = 23'((mag << (5'd31 - msb)) >> 8);
    expo = 8'(msb) + EXP_BIAS;
    flt  = '0;
    if (mag >= FTZ_LIMIT) flt = {sign, expo, mant};
  end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC returning cos or sin of a float32 angle (radians), with a
// Nios II style start/done handshake and a global clock enable.
module cordic_sincos
  import cordic_pkg::*;
#(
  parameter int unsigned ITERATIONS = 16,
  parameter int unsigned UNROLL     = 4,
  parameter int unsigned FRAC_BITS  = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic        n,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result,
  output logic        busy
);

  localparam logic [31:0] ONE_FIX  = 32'(1) << FRAC_BITS;
  localparam logic [7:0]  ZERO_EXP = 8'(127 - FRAC_BITS);
  localparam logic [7:0]  SHL_EXP  = 8'(150 - FRAC_BITS);
  localparam logic [31:0] K_SCALED = K_FIX >> (30 - FRAC_BITS);
  localparam logic [5:0]  LAST     = 6'(ITERATIONS);

  state_t             state, state_n;
  logic [4:0]         cnt;
  logic signed [31:0] x, y, z;
  logic               mode, nan_flag;

  // float-to-fixed input conversion
  logic               a_sign, nan_in;
  logic [7:0]         a_exp;
  logic [22:0]        a_man;
  logic [31:0]        mag_in;
  logic signed [31:0] z_in;

  always_comb begin
    a_sign = dataa[31];
    a_exp  = dataa[30:23];
    a_man  = dataa[22:0];
    nan_in = (a_exp == 8'hFF);
    mag_in = '0;
    if (nan_in || a_exp < ZERO_EXP)
      mag_in = '0;
    else if (a_exp > 8'd127 || (a_exp == 8'd127 && a_man != '0))
      mag_in = ONE_FIX;
    else if (a_exp >= SHL_EXP)
      mag_in = {8'd0, 1'b1, a_man} << (a_exp - SHL_EXP);
    else
      mag_in = {8'd0, 1'b1, a_man} >> (SHL_EXP - a_exp);
    z_in = a_sign ? $signed(32'(-mag_in)) : $signed(mag_in);
  end

  // UNROLL chained micro-rotations per clock
  logic signed [31:0] xs [UNROLL+1];
  logic signed [31:0] ys [UNROLL+1];
  logic signed [31:0] zs [UNROLL+1];

  always_comb begin
    xs[0] = x;
    ys[0] = y;
    zs[0] = z;
    for (int unsigned k = 0; k < UNROLL; k++) begin
      if (!zs[k][31]) begin
        xs[k+1] = xs[k] - (ys[k] >>> 5'(cnt + 5'(k)));
        ys[k+1] = ys[k] + (xs[k] >>> 5'(cnt + 5'(k)));
        zs[k+1] = zs[k] - $signed(atan_fix(5'(cnt + 5'(k))) >> (30 - FRAC_BITS));
      end else begin
        xs[k+1] = xs[k] + (ys[k] >>> 5'(cnt + 5'(k)));
        ys[k+1] = ys[k] - (xs[k] >>> 5'(cnt + 5'(k)));
        zs[k+1] = zs[k] + $signed(atan_fix(5'(cnt + 5'(k))) >> (30 - FRAC_BITS));
      end
    end
  end

  logic [31:0] pack_src, pack_flt;
  assign pack_src = (mode == MODE_SIN) ? y : x;

  cordic_fix2float #(
    .FRAC_BITS(FRAC_BITS),
    .FTZ_EXP  (ITERATIONS - 1)
  ) u_fix2float (
    .fix(pack_src),
    .flt(pack_flt)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = ITER;
      ITER:    if (({1'b0, cnt} + 6'(UNROLL)) == LAST) state_n = PACK;
      PACK:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // done is only rewritten on enabled edges, so a pulse stretches while clk_en is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      x        <= '0;
      y        <= '0;
      z        <= '0;
      mode     <= MODE_COS;
      nan_flag <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else if (clk_en) begin
      state <= state_n;
      done  <= (state == PACK);
      case (state)
        IDLE: if (start) begin
          mode     <= n;
          z        <= z_in;
          nan_flag <= nan_in;
          x        <= $signed(K_SCALED);
          y        <= '0;
          cnt      <= '0;
        end
        ITER: begin
          x   <= xs[UNROLL];
          y   <= ys[UNROLL];
          z   <= zs[UNROLL];
          cnt <= 5'(cnt + 5'(UNROLL));
        end
        PACK: result <= nan_flag ? QNAN : pack_flt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sincos.sv
// Self-checking bench for cordic_sincos: real-valued sin/cos reference model,
// handshake/latency scenarios and a parameter sweep over three extra instances.
module tb_cordic_sincos;

  logic        clk = 1'b0;
  logic        reset, clk_en, start, start_s, n;
  logic [31:0] dataa;
  logic        done, busy;
  logic [31:0] result;
  logic        done_a, done_b, done_c, busy_a, busy_b, busy_c;
  logic [31:0] result_a, result_b, result_c;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cordic_sincos #(.ITERATIONS(16), .UNROLL(4), .FRAC_BITS(30)) u_dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start), .n(n), .dataa(dataa),
    .done(done), .result(result), .busy(busy));

  cordic_sincos #(.ITERATIONS(16), .UNROLL(1), .FRAC_BITS(30)) u_sweep_a (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_s), .n(n), .dataa(dataa),
    .done(done_a), .result(result_a), .busy(busy_a));

  cordic_sincos #(.ITERATIONS(24), .UNROLL(8), .FRAC_BITS(30)) u_sweep_b (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_s), .n(n), .dataa(dataa),
    .done(done_b), .result(result_b), .busy(busy_b));

  cordic_sincos #(.ITERATIONS(28), .UNROLL(4), .FRAC_BITS(30)) u_sweep_c (
    .clk(clk), .reset(reset), .clk_en(clk_en), .start(start_s), .n(n), .dataa(dataa),
    .done(done_c), .result(result_c), .busy(busy_c));

  // ---------------- reference model ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r * 0.5;
    return r;
  endfunction

  function automatic real f32_val(input logic [31:0] b);
    real v;
    if (b[30:23] == 8'd0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * pow2(int'(b[30:23]) - 127);
    return b[31] ? -v : v;
  endfunction

  // angle clamped to [-1,1]; float32 output truncation adds up to one ulp near 1.0
  function automatic real model(input logic mode, input logic [31:0] a);
    real ang = f32_val(a);
    if (ang > 1.0)  ang = 1.0;
    if (ang < -1.0) ang = -1.0;
    return mode ? $sin(ang) : $cos(ang);
  endfunction

  function automatic real tol_for(input int it);
    return pow2(3 - it) + pow2(-23);
  endfunction

  function automatic real abs_err(input logic [31:0] got, input real expv);
    real d = f32_val(got) - expv;
    return (d < 0.0) ? -d : d;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic wait_done(output int lat, output int busy_cycles, output logic [31:0] res);
    int k = 0;
    busy_cycles = 0;
    while (done !== 1'b1 && k < 40) begin
      if (busy === 1'b1) busy_cycles++;
      @(negedge clk);
      k++;
    end
    lat = k;
    res = result;
  endtask

  task automatic run_op(input logic mode, input logic [31:0] a,
                        output int lat, output int busy_cycles, output logic [31:0] res);
    @(negedge clk);
    start = 1'b1; n = mode; dataa = a;
    @(negedge clk);
    start = 1'b0; n = 1'($urandom); dataa = $urandom;
    wait_done(lat, busy_cycles, res);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0; clk_en = 1'b1; start = 1'b0; start_s = 1'b0; n = 1'b0; dataa = '0;
    repeat (3) @(negedge clk);
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (result !== 32'h0) $display("FAIL reset_result: got %h expected 00000000", result); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc;
    logic [31:0] res;
    real expv, tol;
    tol = tol_for(16);
    run_op(1'b0, 32'h3F80_0000, lat, bc, res);
    expv = model(1'b0, 32'h3F80_0000);
    total++; if (lat !== 5) $display("FAIL cos1_latency: got %0d expected 5", lat); else passed++;
    total++; if (bc !== 5) $display("FAIL cos1_busy_cycles: got %0d expected 5", bc); else passed++;
    total++; if (!(abs_err(res, expv) <= tol))
      $display("FAIL cos1_value: got %h (%f) expected %f", res, f32_val(res), expv); else passed++;

    run_op(1'b1, 32'hBF00_0000, lat, bc, res);
    expv = model(1'b1, 32'hBF00_0000);
    total++; if (!(abs_err(res, expv) <= tol))
      $display("FAIL sin_m0p5_value: got %h (%f) expected %f", res, f32_val(res), expv); else passed++;

    run_op(1'b0, 32'h0000_0000, lat, bc, res);
    expv = model(1'b0, 32'h0);
    total++; if (!(abs_err(res, expv) <= tol))
      $display("FAIL cos0_value: got %h (%f) expected %f", res, f32_val(res), expv); else passed++;

    run_op(1'b1, 32'h0000_0000, lat, bc, res);
    total++; if (res !== 32'h0000_0000) $display("FAIL sin0_exact: got %h expected 00000000", res); else passed++;
  endtask

  task automatic test_boundaries;
    int lat, bc;
    logic [31:0] res;
    real expv, tol;
    logic [31:0] vals [4] = '{32'h3380_0000, 32'h3080_0000, 32'h4040_0000, 32'hC040_0000};
    logic        mds  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    tol = tol_for(16);
    for (int i = 0; i < 4; i++) begin
      run_op(mds[i], vals[i], lat, bc, res);
      expv = model(mds[i], vals[i]);
      total++; if (!(abs_err(res, expv) <= tol))
        $display("FAIL boundary_%0d: input %h got %h (%f) expected %f", i, vals[i], res, f32_val(res), expv);
      else passed++;
    end
    run_op(1'b0, 32'h7FC0_0000, lat, bc, res);
    total++; if (res !== 32'h7FC0_0000) $display("FAIL nan_result: got %h expected 7fc00000", res); else passed++;
    total++; if (lat !== 5) $display("FAIL nan_latency: got %0d expected 5", lat); else passed++;
    run_op(1'b1, 32'hFF80_0000, lat, bc, res);
    total++; if (res !== 32'h7FC0_0000) $display("FAIL neginf_result: got %h expected 7fc00000", res); else passed++;
  endtask

  task automatic test_start_held;
    int dones = 0, first = -1;
    @(negedge clk);
    start = 1'b1; n = 1'b0; dataa = 32'h3F00_0000;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (k == 2) start = 1'b0;
      if (done === 1'b1) begin
        dones++;
        if (first < 0) first = k;
      end
    end
    total++; if (dones !== 1) $display("FAIL start_held_dones: got %0d expected 1", dones); else passed++;
    total++; if (first !== 5) $display("FAIL start_held_latency: got %0d expected 5", first); else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [31:0] res;
    real expv;
    run_op(1'b0, 32'h3E80_0000, lat, bc, res);
    start = 1'b1; n = 1'b1; dataa = 32'h3F40_0000;
    @(negedge clk);
    start = 1'b0; n = 1'b0; dataa = $urandom;
    wait_done(lat, bc, res);
    expv = model(1'b1, 32'h3F40_0000);
    total++; if (lat !== 5) $display("FAIL b2b_latency: got %0d expected 5", lat); else passed++;
    total++; if (!(abs_err(res, expv) <= tol_for(16)))
      $display("FAIL b2b_value: got %h (%f) expected %f", res, f32_val(res), expv); else passed++;
  endtask

  task automatic test_clk_en;
    int lat, bc, hi;
    logic [31:0] res;
    real expv;
    @(negedge clk);
    start = 1'b1; n = 1'b0; dataa = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (3) @(negedge clk);
    clk_en = 1'b1;
    wait_done(lat, bc, res);
    lat = lat + 4;
    expv = model(1'b0, 32'h3F80_0000);
    total++; if (lat !== 8) $display("FAIL clken_latency: got %0d expected 8", lat); else passed++;
    total++; if (!(abs_err(res, expv) <= tol_for(16)))
      $display("FAIL clken_value: got %h (%f) expected %f", res, f32_val(res), expv); else passed++;
    hi = (done === 1'b1) ? 1 : 0;
    clk_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1) hi++;
    end
    clk_en = 1'b1;
    @(negedge clk);
    total++; if (hi !== 4) $display("FAIL done_stretch: got %0d high samples expected 4", hi); else passed++;
    total++; if (done !== 1'b0) $display("FAIL done_stretch_end: got %b expected 0", done); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, bc, dones = 0;
    logic [31:0] res;
    real expv;
    @(negedge clk);
    start = 1'b1; n = 1'b1; dataa = 32'h3F80_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else passed++;
    total++; if (result !== 32'h0) $display("FAIL rstmid_result: got %h expected 00000000", result); else passed++;
    @(negedge clk);
    reset = 1'b1;
    repeat (15) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    total++; if (dones !== 0) $display("FAIL rstmid_no_done: got %0d dones expected 0", dones); else passed++;
    run_op(1'b1, 32'h3F80_0000, lat, bc, res);
    expv = model(1'b1, 32'h3F80_0000);
    total++; if (lat !== 5) $display("FAIL rstmid_fresh_latency: got %0d expected 5", lat); else passed++;
    total++; if (!(abs_err(res, expv) <= tol_for(16)))
      $display("FAIL rstmid_fresh_value: got %h (%f) expected %f", res, f32_val(res), expv); else passed++;
  endtask

  task automatic test_random;
    int lat, bc;
    logic [31:0] res, a;
    logic md;
    real expv;
    for (int i = 0; i < 32; i++) begin
      a  = {1'($urandom), 8'(100 + $urandom_range(0, 27)), 23'($urandom)};
      md = 1'($urandom);
      run_op(md, a, lat, bc, res);
      expv = model(md, a);
      total++; if (lat !== 5 || !(abs_err(res, expv) <= tol_for(16)))
        $display("FAIL random_%0d: mode %b input %h got %h (%f) lat %0d expected %f lat 5",
                 i, md, a, res, f32_val(res), lat, expv);
      else passed++;
    end
  endtask

  task automatic test_sweep;
    int lat_a, lat_b, lat_c, k;
    logic [31:0] ra, rb, rc, a;
    logic md;
    real expv;
    for (int i = 0; i < 64; i++) begin
      a  = {1'($urandom), 8'(100 + $urandom_range(0, 26)), 23'($urandom)};
      md = 1'(i % 2);
      lat_a = -1; lat_b = -1; lat_c = -1;
      ra = '0; rb = '0; rc = '0;
      @(negedge clk);
      start_s = 1'b1; n = md; dataa = a;
      @(negedge clk);
      start_s = 1'b0; n = ~md; dataa = $urandom;
      k = 0;
      while ((lat_a < 0 || lat_b < 0 || lat_c < 0) && k < 60) begin
        if (done_a === 1'b1 && lat_a < 0) begin lat_a = k; ra = result_a; end
        if (done_b === 1'b1 && lat_b < 0) begin lat_b = k; rb = result_b; end
        if (done_c === 1'b1 && lat_c < 0) begin lat_c = k; rc = result_c; end
        @(negedge clk);
        k++;
      end
      expv = model(md, a);
      total++; if (lat_a !== 17) $display("FAIL sweep16x1_latency_%0d: got %0d expected 17", i, lat_a); else passed++;
      total++; if (lat_b !== 4)  $display("FAIL sweep24x8_latency_%0d: got %0d expected 4", i, lat_b); else passed++;
      total++; if (lat_c !== 8)  $display("FAIL sweep28x4_latency_%0d: got %0d expected 8", i, lat_c); else passed++;
      total++; if (!(abs_err(ra, expv) <= tol_for(16)))
        $display("FAIL sweep16x1_value_%0d: input %h got %h (%f) expected %f", i, a, ra, f32_val(ra), expv); else passed++;
      total++; if (!(abs_err(rb, expv) <= tol_for(24)))
        $display("FAIL sweep24x8_value_%0d: input %h got %h (%.9f) expected %.9f", i, a, rb, f32_val(rb), expv); else passed++;
      total++; if (!(abs_err(rc, expv) <= tol_for(28)))
        $display("FAIL sweep28x4_value_%0d: input %h got %h (%.9f) expected %.9f", i, a, rc, f32_val(rc), expv); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_start_held();
    test_back_to_back();
    test_clk_en();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish before 500000");
    $fatal(1);
  end

endmodule
